// File: rtl/zap_pkg.sv
// Shared types and limits for the multi-channel light-gun controller.
// Holds the shot-sequence state encoding and the legal parameter ranges.
// No logic; imported by zap_multi and zap_rr_arb.
package zap_pkg;

   // Shot-sequence states; encoding is fixed so it can be probed externally.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      LOOK  = 2'd2,
      WAIT  = 2'd3
   } zap_state_t;

   // Legal parameter ranges, checked at elaboration by the top.
   localparam int N_CH_MIN      = 1;
   localparam int N_CH_MAX      = 8;
   localparam int BLANK_CYC_MIN = 1;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zap_rr_arb.sv
// Round-robin grant for pending light-gun channels.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none; caller decides when to take the grant.
module zap_rr_arb
   import zap_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int IDX_W = idx_width(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [N_CH-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   // Search starts one past the last served channel and wraps; with a
   // single channel the search always lands on channel 0.
   always_comb begin
      int c;
      c       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         c = (int'(last) + k) % N_CH;
         if (!gnt_vld && req[c]) begin
            gnt_vld = 1'b1;
            gnt[c]  = 1'b1;
            gnt_idx = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/zap_multi.sv
// Multi-channel light-gun controller: arbitrates trigger presses, runs blank/look/wait shot window.
// Latency: trigger low sampled at E0 -> shot/flash/busy asserted after E2 when idle and uncontested.
// Backpressure: presses during a sequence are held as pending bits; optional hit counters under ZAP_HIT_CNT_EN.
module zap_multi
   import zap_pkg::*;
#(
   parameter int  N_CH       = 2,
   parameter int  BLANK_CYC  = 1000000,
   parameter int  WINDOW_CYC = 2500000,
   parameter int  CNT_W      = 8,
   localparam int IDX_W      = idx_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       sensor,
   input  logic [N_CH-1:0]       trigger,
   input  logic                  hit_clr,
   output logic [N_CH-1:0]       shot,
   output logic [N_CH-1:0]       hit,
   output logic                  flash,
   output logic                  busy,
   output logic [IDX_W-1:0]      active_ch,
   output logic [N_CH*CNT_W-1:0] hit_cnt
);

   localparam int            CW        = $clog2(WINDOW_CYC + 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] WIN_END   = CW'(WINDOW_CYC - 1);

   if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
      $error("zap_multi: N_CH must be within 1..8");
   end
   if (BLANK_CYC < BLANK_CYC_MIN) begin : g_bad_blank
      $error("zap_multi: BLANK_CYC must be at least 1");
   end
   if (WINDOW_CYC <= BLANK_CYC) begin : g_bad_window
      $error("zap_multi: WINDOW_CYC must exceed BLANK_CYC");
   end

   logic [N_CH-1:0]  trg_s1, trg_s2, trg_arm;
   logic [N_CH-1:0]  sen_s1, sen_s2;
   logic [1:0]       sync_ok;
   logic [N_CH-1:0]  press, pend, req, arb_gnt;
   logic [IDX_W-1:0] arb_idx, arb_last;
   logic             arb_vld;
   logic             served;
   logic             grant_take;
   logic             sen_act;
   logic             hit_evt;
   logic [CW-1:0]    cnt;
   logic [N_CH-1:0]  ch_onehot;
   zap_state_t       state, state_nxt;

   // Two-flop synchronizers; trigger is inverted so a pulled-low trigger reads as 1.
   // trg_arm only opens once the synchronizer holds real samples and the trigger
   // has been seen released, so a trigger held through reset never fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trg_s1  <= '0;
         trg_s2  <= '0;
         sen_s1  <= '0;
         sen_s2  <= '0;
         sync_ok <= '0;
         trg_arm <= '0;
      end else begin
         trg_s1  <= ~trigger;
         trg_s2  <= trg_s1;
         sen_s1  <= sensor;
         sen_s2  <= sen_s1;
         sync_ok <= {sync_ok[0], 1'b1};
         trg_arm <= sync_ok[1] ? ~trg_s2 : '0;
      end
   end

   assign press = trg_s2 & trg_arm;
   assign req   = pend | press;

   // Until the first grant after reset, search from channel 0.
   assign arb_last = served ? active_ch : IDX_W'(N_CH - 1);

   zap_rr_arb #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (req),
      .last    (arb_last),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   assign sen_act = sen_s2[active_ch];

   // Next state: window timeout outranks a same-cycle sensor hit in LOOK.
   always_comb begin
      state_nxt  = state;
      grant_take = 1'b0;
      hit_evt    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_vld) begin
               state_nxt  = BLANK;
               grant_take = 1'b1;
            end
         end
         BLANK: begin
            if (cnt == BLANK_END) state_nxt = LOOK;
         end
         LOOK: begin
            if (cnt == WIN_END) begin
               state_nxt = IDLE;
            end else if (sen_act) begin
               state_nxt = WAIT;
               hit_evt   = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == WIN_END) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, window counter, served channel and pending presses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= '0;
         active_ch <= '0;
         served    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_take) begin
            cnt       <= '0;
            active_ch <= arb_idx;
            served    <= 1'b1;
            pend      <= req & ~arb_gnt;
         end else begin
            pend <= req;
            if (busy) cnt <= cnt + CW'(1);
         end
      end
   end

   assign busy      = (state != IDLE);
   assign flash     = (state == BLANK) || (state == LOOK);
   assign ch_onehot = N_CH'(1) << active_ch;
   assign shot      = busy ? ch_onehot : '0;
   assign hit       = (state == WAIT) ? ch_onehot : '0;

`ifdef ZAP_HIT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [N_CH*CNT_W-1:0] cnt_q;

   // Per-channel saturating hit counters; a clear overrides a same-cycle hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (hit_clr) begin
         cnt_q <= '0;
      end else if (hit_evt) begin
         for (int i = 0; i < N_CH; i++) begin
            if (active_ch == IDX_W'(i) && cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)
               cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end

   assign hit_cnt = cnt_q;
`else
   logic unused_cnt_in;
   assign unused_cnt_in = hit_clr ^ hit_evt;
   assign hit_cnt       = '0;
`endif

endmodule

// File: tb/tb_zap_multi.sv
// Directed bench for zap_multi with N_CH=2, BLANK_CYC=4, WINDOW_CYC=16, CNT_W=2.
// Edges are counted from E0 (first edge sampling the trigger low); outputs are sampled 1 time unit after each edge.
// Expected hit counts follow whether ZAP_HIT_CNT_EN is defined for the build.
module tb_zap_multi;

   localparam int N_CH       = 2;
   localparam int BLANK_CYC  = 4;
   localparam int WINDOW_CYC = 16;
   localparam int CNT_W      = 2;

`ifdef ZAP_HIT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sensor;
   logic [1:0] trigger;
   logic       hit_clr;
   logic [1:0] shot;
   logic [1:0] hit;
   logic       flash;
   logic       busy;
   logic [0:0] active_ch;
   logic [3:0] hit_cnt;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   zap_multi #(
      .N_CH       (N_CH),
      .BLANK_CYC  (BLANK_CYC),
      .WINDOW_CYC (WINDOW_CYC),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sensor    (sensor),
      .trigger   (trigger),
      .hit_clr   (hit_clr),
      .shot      (shot),
      .hit       (hit),
      .flash     (flash),
      .busy      (busy),
      .active_ch (active_ch),
      .hit_cnt   (hit_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed expected hit_cnt: channel 1 in [3:2], channel 0 in [1:0].
   function automatic logic [3:0] cnt_exp(input int c0, input int c1);
      logic [3:0] v;
      v = {2'(c1), 2'(c0)};
      return CNT_EN ? v : 4'h0;
   endfunction

   // One press on channel ch from idle. Raw sensor[ch] rises after edge s_on and
   // falls after edge s_off; hit_clr is high for edge clr_at only. hit_e is the
   // edge at which WAIT is expected (<=0 for no hit). Checks edges E1..E18.
   task automatic run_seq(input int ch, input int s_on, input int s_off,
                          input int hit_e, input int clr_at, input string tag);
      logic [1:0] oh;
      logic [1:0] shot_x;
      logic [1:0] hit_x;
      logic       busy_x;
      logic       flash_x;
      int         last_flash;
      oh         = 2'b01 << ch;
      last_flash = (hit_e > 0) ? hit_e - 1 : 17;
      trigger[ch] = 1'b0;
      tick();
      for (int k = 1; k <= 18; k++) begin
         tick();
         busy_x  = (k >= 2 && k <= 17);
         flash_x = (k >= 2 && k <= last_flash);
         shot_x  = busy_x ? oh : 2'b00;
         hit_x   = (hit_e > 0 && k >= hit_e && k <= 17) ? oh : 2'b00;
         chk($sformatf("%s_e%0d", tag, k), {busy, flash, shot, hit},
             {busy_x, flash_x, shot_x, hit_x});
         if (k == 2) begin
            chk($sformatf("%s_ch", tag), active_ch, ch);
            trigger[ch] = 1'b1;
         end
         if (k == s_on)       sensor[ch] = 1'b1;
         if (k == s_off)      sensor[ch] = 1'b0;
         if (k == clr_at - 1) hit_clr = 1'b1;
         if (k == clr_at)     hit_clr = 1'b0;
      end
   endtask

   initial begin
      int busy_seen;
      rst     = 1'b1;
      sensor  = 2'b00;
      trigger = 2'b11;
      hit_clr = 1'b0;
      tick();
      chk("reset_state", {active_ch, busy, flash, shot, hit, hit_cnt}, 11'd0);
      rst = 1'b0;
      repeat (3) tick();

      // Hit on channel 0: synced sensor high from 2nd LOOK cycle.
      run_seq(0, 5, 17, 8, -1, "hit0");
      chk("hit0_cnt", hit_cnt, cnt_exp(1, 0));

      // Sensor only during BLANK is ignored.
      run_seq(0, 2, 3, -1, -1, "blank_only");
      chk("blank_only_cnt", hit_cnt, cnt_exp(1, 0));

      // Sensor arriving in the final LOOK cycle: timeout wins, no hit.
      run_seq(0, 15, 18, -1, -1, "late_sensor");
      chk("late_sensor_cnt", hit_cnt, cnt_exp(1, 0));

      // Simultaneous presses after reset: ch0 first, ch1 right after.
      rst = 1'b1;
      tick();
      chk("reset2_state", {active_ch, busy, hit_cnt}, 6'd0);
      rst = 1'b0;
      repeat (3) tick();
      for (int p = 1; p <= 2; p++) begin
         trigger = 2'b00;
         tick();
         tick();
         tick();
         chk($sformatf("pair%0d_first", p), {active_ch, shot, busy}, {1'b0, 2'b01, 1'b1});
         trigger = 2'b11;
         repeat (16) tick();
         chk($sformatf("pair%0d_gap", p), busy, 1'b0);
         tick();
         chk($sformatf("pair%0d_second", p), {active_ch, shot, busy}, {1'b1, 2'b10, 1'b1});
         repeat (16) tick();
         chk($sformatf("pair%0d_done", p), busy, 1'b0);
         tick();
      end

      // Channel 1 hits with sensor 0 held high (must be ignored); saturate at 3.
      sensor[0] = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         run_seq(1, 5, 17, 8, -1, $sformatf("h1_%0d", n));
         chk($sformatf("h1_%0d_cnt", n), hit_cnt, cnt_exp(0, (n > 3) ? 3 : n));
      end
      // Fifth hit with hit_clr on the same edge: clear wins.
      run_seq(1, 5, 17, 8, 8, "h1_clr");
      chk("h1_clr_cnt", hit_cnt, cnt_exp(0, 0));
      sensor[0] = 1'b0;
      run_seq(1, 5, 17, 8, -1, "h1_after_clr");
      chk("h1_after_clr_cnt", hit_cnt, cnt_exp(0, 1));

      // Reset in LOOK with trigger 1 held low.
      trigger[1] = 1'b0;
      repeat (7) tick();
      chk("pre_rst_look", {active_ch, busy, flash, shot, hit}, {1'b1, 1'b1, 1'b1, 2'b10, 2'b00});
      rst = 1'b1;
      #1;
      chk("async_rst", {active_ch, busy, flash, shot, hit, hit_cnt}, 11'd0);
      tick();
      rst = 1'b0;
      busy_seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (busy) busy_seen++;
      end
      chk("held_trigger_no_fire", busy_seen, 0);
      trigger[1] = 1'b1;
      repeat (3) tick();
      trigger[1] = 1'b0;
      tick();
      tick();
      tick();
      chk("repress_start", {active_ch, shot, busy}, {1'b1, 2'b10, 1'b1});

      // Release then re-press on the active channel: served after this sequence.
      trigger[1] = 1'b1;
      tick();
      tick();
      trigger[1] = 1'b0;
      repeat (4) tick();
      trigger[1] = 1'b1;
      repeat (10) tick();
      chk("self_pend_gap", busy, 1'b0);
      tick();
      chk("self_pend_serve", {active_ch, shot, busy}, {1'b1, 2'b10, 1'b1});
      repeat (16) tick();
      chk("self_pend_done", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
